wb_port_arb: RTL
================

Name: wb_port_arb

Overview:
- Shares the single register-file write port between NUM_REQ commit sources. Port 0 is the EX/ALU commit path; port 1 is the LSU load-response path.
- Sits between the execute-side producers and the regfile.
- Uses valid/ready handshakes and round-robin arbitration, with a registered write request that has 1-cycle latency.
- Counts commits and halts all commits once an ebreak uop has committed.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- XLEN, 32, data and PC width.
- REG_AW, 5, register index width.
- CNT_W, 32, commit counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-port request valid.
- req_ready_o  out  NUM_REQ  per-port grant; transfer happens when valid&ready.
- req_rd_i  in  NUM_REQ*REG_AW  per-port destination register.
- req_wen_i  in  NUM_REQ  per-port rd write enable.
- req_wdata_i  in  NUM_REQ*XLEN  per-port write data.
- req_pc_i  in  NUM_REQ*XLEN  per-port uop PC.
- req_ebreak_i  in  NUM_REQ  per-port ebreak flag.
- wb_valid_o  out  1  registered commit valid.
- wb_rd_wen_o  out  1  regfile write enable.
- wb_rd_o  out  REG_AW  regfile write index.
- wb_rd_wdata_o  out  XLEN  regfile write data.
- wb_pc_o  out  XLEN  PC of the committed uop.
- halt_o  out  1  sticky; set once an ebreak has committed.
- halt_pc_o  out  XLEN  PC of the ebreak uop.
- commit_cnt_o  out  CNT_W  number of committed uops.

Behaviour:
- Reset (rst_ni=0, async) clears wb_valid_o, wb_rd_wen_o, wb_rd_o, wb_rd_wdata_o, wb_pc_o, halt_o, halt_pc_o and commit_cnt_o to 0. The FSM enters RUN and the RR pointer is set to NUM_REQ-1, so port 0 has first priority.
- FSM has two states, RUN and HALT.
- RUN, arbitration:
  - Combinational round-robin. Search starts at the index last_grant+1 (mod NUM_REQ) and takes the first port with req_valid_i=1.
  - At most one bit of req_ready_o is high, and only for a valid port. It is a pure function of req_valid_i and state; it does not depend on wdata.
  - No valid port means no grant and no change to the pointer.
- RUN, on a grant:
  - last_grant <= granted index.
  - The output register loads rd, data and pc, and wb_valid_o <= 1.
  - wb_rd_wen_o <= wen & (rd != 0); writes to x0 are suppressed.
  - commit_cnt_o increments by 1 and wraps at 2^CNT_W.
- RUN, no grant: wb_valid_o <= 0 and wb_rd_wen_o <= 0. The data fields hold their values.
- Latency: a handshake at cycle N produces the regfile write in the cycle after edge N. There is no buffering; ports hold their request until granted.
- Ebreak: a granted request with ebreak=1 still commits normally, including its rd write if enabled. On the same edge, the FSM goes to HALT, halt_o <= 1 and halt_pc_o <= the request's pc.
- HALT:
  - req_ready_o = 0 for all ports.
  - wb_valid_o and wb_rd_wen_o are 0 from the next cycle onward.
  - The counter is frozen.
  - Only reset leaves HALT.
- Simultaneous valid on all ports: ports are served in strict rotation, so port p waits at most NUM_REQ-1 grants.
- Same rd from two ports in the same cycle: RR order decides. The later grant's value wins in the regfile. The arbiter does not merge requests.
- Reset mid-stream: any pending commit in the output register is dropped and no write is issued. Requesters re-present their requests after reset.

Decomposition:
- liang_pkg gains:
  - wb_src_req_t {rd_wen, rd, wdata, pc, ebreak};
  - arb_state_e {ARB_RUN, ARB_HALT};
  - WB_SRC_EXU=0 and WB_SRC_LSU=1.
- The existing wb_req_t is reused for the output triple.
- One sub-module, rr_arbiter #(N): combinational grant from req and last_grant, returning a one-hot grant plus the encoded index. It is reusable by the LSU/bus arbiters.

Test Plan:
- Single port 0: rd=3, wen=1, wdata=0xDEADBEEF, pc=0x80000000 → ready0=1 the same cycle. The next cycle shows wb_valid_o=1, wb_rd_wen_o=1, wb_rd_o=3, wdata=0xDEADBEEF; commit_cnt_o=1.
- Both ports continuously valid for 6 cycles → grants go 0,1,0,1,0,1. No port is ready for two consecutive cycles while the other is valid; commit_cnt_o=6.
- Port 1 presents rd=0, wen=1, wdata=5 → wb_valid_o=1 and wb_rd_wen_o=0.
- Port 1 presents ebreak with rd=10, wen=1, wdata=7, pc=0x80000040 while port 0 is valid → the ebreak commits: wb_rd_o=10, halt_o=1, halt_pc_o=0x80000040. After that, port 0 never sees ready and wb_valid_o stays 0 for 10 cycles.
- Drop rst_ni asynchronously mid-cycle while a commit is pending → all outputs are 0 immediately. After release, port 0 is granted first even if both are valid.
- With CNT_W=4, perform 17 commits → commit_cnt_o=1 (wrap).

Source files
------------

// File: rtl/wb_port_arb_pkg.sv
// Shared types for the writeback port arbiter: requester payload, output
// triple, arbiter FSM states and requester index assignments.
package wb_port_arb_pkg;

  localparam int unsigned WB_XLEN   = 32;
  localparam int unsigned WB_REG_AW = 5;

  // Fixed requester slots on the shared regfile write port
  localparam int unsigned WB_SRC_EXU = 0;
  localparam int unsigned WB_SRC_LSU = 1;

  typedef enum logic [0:0] {
    ARB_RUN  = 1'b0,
    ARB_HALT = 1'b1
  } arb_state_e;

  // Payload presented by one commit source
  typedef struct packed {
    logic                 rd_wen;
    logic [WB_REG_AW-1:0] rd;
    logic [WB_XLEN-1:0]   wdata;
    logic [WB_XLEN-1:0]   pc;
    logic                 ebreak;
  } wb_src_req_t;

  // Regfile write triple
  typedef struct packed {
    logic                 rd_wen;
    logic [WB_REG_AW-1:0] rd;
    logic [WB_XLEN-1:0]   wdata;
  } wb_req_t;

  // x0 is hardwired to zero, so a write to it is never issued
  function automatic logic rd_writes(input logic wen, input logic [WB_REG_AW-1:0] rd);
    return wen & (rd != '0);
  endfunction

endpackage

// File: rtl/wb_port_arb_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req        - per-requester request
//   last_grant - index granted most recently; search starts one above it
//   gnt        - one-hot grant (all zero when nothing requests)
//   gnt_idx    - encoded index of the granted requester
//   gnt_valid  - some requester was granted
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid
);

  localparam int unsigned IDX_W = $clog2(N);

  // Walk the requesters in rotation order, last_grant+1 first
  always_comb begin
    int unsigned idx;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last_grant) + k) % N;
      if (!gnt_valid && req[IDX_W'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(idx);
      end
    end
    if (gnt_valid) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arb.sv
// Shares the single regfile write port between NUM_REQ commit sources
// (port 0 = EX/ALU, port 1 = LSU load response) with round-robin
// arbitration, a registered 1-cycle write request, a commit counter and a
// sticky halt once an ebreak uop has committed.
// Ports:
//   clk_i, rst_ni          - clock, async active-low reset
//   req_valid_i/ready_o    - per-port handshake; transfer on valid&ready
//   req_rd_i/wen_i/wdata_i - per-port destination register write
//   req_pc_i, req_ebreak_i - per-port uop PC and ebreak flag
//   wb_valid_o, wb_rd_*    - registered commit and regfile write
//   wb_pc_o                - PC of the committed uop
//   halt_o, halt_pc_o      - sticky halt and PC of the ebreak
//   commit_cnt_o           - committed uop count (wraps)
module wb_port_arb
  import wb_port_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = WB_XLEN,
  parameter int unsigned REG_AW  = WB_REG_AW,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*REG_AW-1:0] req_rd_i,
  input  logic [NUM_REQ-1:0]      req_wen_i,
  input  logic [NUM_REQ*XLEN-1:0] req_wdata_i,
  input  logic [NUM_REQ*XLEN-1:0] req_pc_i,
  input  logic [NUM_REQ-1:0]      req_ebreak_i,
  output logic                    wb_valid_o,
  output logic                    wb_rd_wen_o,
  output logic [REG_AW-1:0]       wb_rd_o,
  output logic [XLEN-1:0]         wb_rd_wdata_o,
  output logic [XLEN-1:0]         wb_pc_o,
  output logic                    halt_o,
  output logic [XLEN-1:0]         halt_pc_o,
  output logic [CNT_W-1:0]        commit_cnt_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Payload structs are sized by the package; reject mismatching overrides
  if (XLEN != WB_XLEN || REG_AW != WB_REG_AW || NUM_REQ < 2) begin : g_bad_cfg
    $error("wb_port_arb: unsupported XLEN/REG_AW/NUM_REQ configuration");
  end

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               commit;
  wb_src_req_t        sel_req;
  wb_req_t            wb_q;
  logic               wb_valid_q;
  logic [XLEN-1:0]    wb_pc_q;
  logic [XLEN-1:0]    halt_pc_q;
  logic [CNT_W-1:0]   cnt_q;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req        (req_valid_i),
    .last_grant (last_grant_q),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx),
    .gnt_valid  (arb_any)
  );

  // Payload of the granted port
  always_comb begin
    sel_req        = '0;
    sel_req.rd_wen = req_wen_i[arb_idx];
    sel_req.rd     = req_rd_i[arb_idx*REG_AW +: REG_AW];
    sel_req.wdata  = req_wdata_i[arb_idx*XLEN +: XLEN];
    sel_req.pc     = req_pc_i[arb_idx*XLEN +: XLEN];
    sel_req.ebreak = req_ebreak_i[arb_idx];
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: an ebreak commit halts for good
  always_comb begin
    state_d = state_q;
    if (state_q == ARB_RUN && arb_any && sel_req.ebreak) begin
      state_d = ARB_HALT;
    end
  end

  // FSM outputs: grants only while running
  always_comb begin
    req_ready_o = '0;
    commit      = 1'b0;
    if (state_q == ARB_RUN) begin
      req_ready_o = arb_gnt;
      commit      = arb_any;
    end
  end

  // Output register, RR pointer, counter and halt PC
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_q         <= '0;
      wb_valid_q   <= 1'b0;
      wb_pc_q      <= '0;
      halt_pc_q    <= '0;
      cnt_q        <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      wb_valid_q <= commit;
      if (commit) begin
        wb_q.rd_wen  <= rd_writes(sel_req.rd_wen, sel_req.rd);
        wb_q.rd      <= sel_req.rd;
        wb_q.wdata   <= sel_req.wdata;
        wb_pc_q      <= sel_req.pc;
        last_grant_q <= arb_idx;
        cnt_q        <= cnt_q + CNT_W'(1);
        if (sel_req.ebreak) begin
          halt_pc_q <= sel_req.pc;
        end
      end else begin
        wb_q.rd_wen <= 1'b0;
      end
    end
  end

  assign wb_valid_o    = wb_valid_q;
  assign wb_rd_wen_o   = wb_q.rd_wen;
  assign wb_rd_o       = wb_q.rd;
  assign wb_rd_wdata_o = wb_q.wdata;
  assign wb_pc_o       = wb_pc_q;
  assign halt_o        = (state_q == ARB_HALT);
  assign halt_pc_o     = halt_pc_q;
  assign commit_cnt_o  = cnt_q;

endmodule
